// File: rtl/ula_seq_ctrl_pkg.sv
// Shared opcodes, ALU select codes, controller states and the ALU control tuple
// used by the ula_seq_ctrl sequencer and its opcode decoder.
package ula_seq_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [1:0] ALUSEL_AND = 2'b00;
  localparam logic [1:0] ALUSEL_OR  = 2'b01;
  localparam logic [1:0] ALUSEL_ADD = 2'b10;
  localparam logic [1:0] ALUSEL_SLT = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StResp
  } state_e;

  typedef struct packed {
    logic       ain;
    logic       bin;
    logic [1:0] sel;
    logic       cin;
  } alu_ctrl_t;

endpackage

// File: rtl/ula_op_decode.sv
// Combinational opcode to ALU control tuple decode. MULU maps to a plain add
// (one shift-add step); the illegal opcode yields an all-zero tuple.
module ula_op_decode
  import ula_seq_ctrl_pkg::*;
(
  input  logic [2:0] op,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_AND:  ctrl = '{ain: 1'b0, bin: 1'b0, sel: ALUSEL_AND, cin: 1'b0};
      OP_OR:   ctrl = '{ain: 1'b0, bin: 1'b0, sel: ALUSEL_OR,  cin: 1'b0};
      OP_ADD:  ctrl = '{ain: 1'b0, bin: 1'b0, sel: ALUSEL_ADD, cin: 1'b0};
      OP_SUB:  ctrl = '{ain: 1'b0, bin: 1'b1, sel: ALUSEL_ADD, cin: 1'b1};
      OP_SLT:  ctrl = '{ain: 1'b0, bin: 1'b1, sel: ALUSEL_SLT, cin: 1'b1};
      OP_NOR:  ctrl = '{ain: 1'b1, bin: 1'b1, sel: ALUSEL_AND, cin: 1'b0};
      OP_MULU: ctrl = '{ain: 1'b0, bin: 1'b0, sel: ALUSEL_ADD, cin: 1'b0};
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ula_seq_ctrl.sv
// Initiator-side sequencer for the 8-bit ripple ALU: single-op request/response
// handshakes, one-cycle ALU ops and an 8-step unsigned shift-add multiply.
module ula_seq_ctrl
  import ula_seq_ctrl_pkg::*;
#(
  parameter int unsigned MUL_ITERS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ain,
  output logic       alu_bin,
  output logic [1:0] alu_operation,
  output logic       alu_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [7:0] rsp_hi,
  output logic       rsp_overflow,
  output logic       rsp_zero,
  output logic       rsp_illegal
);

  localparam logic [2:0] LastIter = 3'(MUL_ITERS - 1);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] mplr_q, mplr_d;
  logic [7:0] mcand_q, mcand_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  alu_ctrl_t  ctrl_q, ctrl_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic [7:0] rsp_hi_q, rsp_hi_d;
  logic       rsp_ovf_q, rsp_ovf_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_ill_q, rsp_ill_d;

  alu_ctrl_t  req_ctrl;
  logic       carry;
  logic [7:0] acc_nx, mplr_nx;

  ula_op_decode u_decode (
    .op   (req_op),
    .ctrl (req_ctrl)
  );

  // Adder carry-out rebuilt from the operand and sum sign bits.
  assign carry = (alu_a_q[7] & alu_b_q[7]) | ((alu_a_q[7] | alu_b_q[7]) & ~alu_result[7]);
  assign {acc_nx, mplr_nx} = {carry, alu_result, mplr_q[7:1]};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    acc_d        = acc_q;
    mplr_d       = mplr_q;
    mcand_d      = mcand_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    ctrl_d       = ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ill_d    = rsp_ill_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          alu_a_d = req_a;
          alu_b_d = req_b;
          ctrl_d  = req_ctrl;
          unique case (req_op)
            OP_MULU: begin
              acc_d   = '0;
              mplr_d  = req_b;
              mcand_d = req_a;
              cnt_d   = '0;
              alu_a_d = '0;
              alu_b_d = req_b[0] ? req_a : '0;
              state_d = StMul;
            end
            OP_ILL: begin
              rsp_result_d = '0;
              rsp_hi_d     = '0;
              rsp_ovf_d    = 1'b0;
              rsp_zero_d   = 1'b1;
              rsp_ill_d    = 1'b1;
              state_d      = StResp;
            end
            default: state_d = StExec;
          endcase
        end
      end
      StExec: begin
        rsp_result_d = alu_result;
        rsp_hi_d     = '0;
        rsp_ovf_d    = ((op_q == OP_ADD) || (op_q == OP_SUB)) & alu_overflow;
        rsp_zero_d   = (alu_result == '0);
        rsp_ill_d    = 1'b0;
        state_d      = StResp;
      end
      StMul: begin
        acc_d  = acc_nx;
        mplr_d = mplr_nx;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == LastIter) begin
          rsp_hi_d     = acc_nx;
          rsp_result_d = mplr_nx;
          rsp_ovf_d    = |acc_nx;
          rsp_zero_d   = ~|{acc_nx, mplr_nx};
          rsp_ill_d    = 1'b0;
          state_d      = StResp;
        end else begin
          alu_a_d = acc_nx;
          alu_b_d = mplr_nx[0] ? mcand_q : '0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          alu_a_d      = '0;
          alu_b_d      = '0;
          ctrl_d       = '0;
          rsp_result_d = '0;
          rsp_hi_d     = '0;
          rsp_ovf_d    = 1'b0;
          rsp_zero_d   = 1'b0;
          rsp_ill_d    = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      acc_q        <= '0;
      mplr_q       <= '0;
      mcand_q      <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      ctrl_q       <= '0;
      rsp_result_q <= '0;
      rsp_hi_q     <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      mplr_q       <= mplr_d;
      mcand_q      <= mcand_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      ctrl_q       <= ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ain       = ctrl_q.ain;
  assign alu_bin       = ctrl_q.bin;
  assign alu_operation = ctrl_q.sel;
  assign alu_cin       = ctrl_q.cin;
  assign rsp_result    = rsp_result_q;
  assign rsp_hi        = rsp_hi_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_illegal   = rsp_ill_q;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl driving a behavioural 8-bit ripple ALU; a response
// model computed with plain arithmetic is compared against the DUT every cycle.
module tb_ula_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [7:0] alu_a, alu_b;
  logic       alu_ain, alu_bin, alu_cin;
  logic [1:0] alu_operation;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result, rsp_hi;
  logic       rsp_overflow, rsp_zero, rsp_illegal;

  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ula_seq_ctrl #(.MUL_ITERS(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ain       (alu_ain),
    .alu_bin       (alu_bin),
    .alu_operation (alu_operation),
    .alu_cin       (alu_cin),
    .alu_result    (alu_result),
    .alu_overflow  (alu_overflow),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_hi        (rsp_hi),
    .rsp_overflow  (rsp_overflow),
    .rsp_zero      (rsp_zero),
    .rsp_illegal   (rsp_illegal)
  );

  // Behavioural ripple ALU: optional operand inversion, then AND/OR/ADD/SLT.
  logic [7:0] aa, bb, sum;
  always_comb begin
    aa = alu_ain ? ~alu_a : alu_a;
    bb = alu_bin ? ~alu_b : alu_b;
    sum = aa + bb + {7'b0, alu_cin};
    case (alu_operation)
      2'b00:   alu_result = aa & bb;
      2'b01:   alu_result = aa | bb;
      2'b10:   alu_result = sum;
      default: alu_result = {7'b0, sum[7]};
    endcase
    alu_overflow = (aa[7] == bb[7]) && (sum[7] != aa[7]);
  end

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       ovf;
    logic       zero;
    logic       ill;
    logic [4:0] ctrl;
  } exp_t;

  function automatic exp_t expect_rsp(input logic [2:0] op, input logic [7:0] a, b);
    exp_t e;
    logic [15:0] p;
    logic [7:0] d;
    e = '{res: 8'h00, hi: 8'h00, ovf: 1'b0, zero: 1'b0, ill: 1'b0, ctrl: 5'b00000};
    case (op)
      3'd0: begin e.res = a & b; e.ctrl = 5'b00000; end
      3'd1: begin e.res = a | b; e.ctrl = 5'b00010; end
      3'd2: begin
        e.res = a + b;
        e.ovf = (a[7] == b[7]) && (e.res[7] != a[7]);
        e.ctrl = 5'b00100;
      end
      3'd3: begin
        e.res = a - b;
        e.ovf = (a[7] != b[7]) && (e.res[7] != a[7]);
        e.ctrl = 5'b01101;
      end
      3'd4: begin d = a - b; e.res = {7'b0, d[7]}; e.ctrl = 5'b01111; end
      3'd5: begin e.res = ~(a | b); e.ctrl = 5'b11000; end
      3'd6: begin
        p = 16'(a) * 16'(b);
        e.res = p[7:0];
        e.hi = p[15:8];
        e.ovf = (p[15:8] != 8'h00);
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 8'h00) && (e.hi == 8'h00);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: idle, waiting out the op latency, or responding.
  logic       m_idle = 1'b1;
  logic       m_valid = 1'b0;
  int         m_wait = 0;
  logic [2:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0;
  exp_t       m_exp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle  <= 1'b0;
        m_op    <= req_op;
        m_a     <= req_a;
        m_b     <= req_b;
        m_exp   <= expect_rsp(req_op, req_a, req_b);
        m_wait  <= (req_op == 3'd6) ? 8 : (req_op == 3'd7) ? 0 : 1;
        m_valid <= (req_op == 3'd7);
      end
    end else if (!m_valid) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(m_idle));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_idle) begin
      check("idle_alu", {alu_a, alu_b, alu_ain, alu_bin, alu_operation, alu_cin}, 32'h0);
    end else if (m_op != 3'd6 && m_op != 3'd7) begin
      check("alu_ops", {alu_a, alu_b}, {m_a, m_b});
      check("alu_ctrl", {alu_ain, alu_bin, alu_operation, alu_cin}, 32'(m_exp.ctrl));
    end
    if (m_valid) begin
      check("rsp_result", rsp_result, m_exp.res);
      check("rsp_hi", rsp_hi, m_exp.hi);
      check("rsp_flags", {rsp_overflow, rsp_zero, rsp_illegal}, {m_exp.ovf, m_exp.zero, m_exp.ill});
    end
  end

  // Issue one request, measure edges from accept to response, check literal values.
  task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] a, b,
                       input logic [7:0] er, eh, input logic eo, ez, ei, input int el);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 32'(n), 32'(el));
    check({nm, "_result"}, rsp_result, er);
    check({nm, "_hi"}, rsp_hi, eh);
    check({nm, "_ovf_zero_ill"}, {rsp_overflow, rsp_zero, rsp_illegal}, {eo, ez, ei});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, "_ready_back"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {req_ready, rsp_valid, rsp_result, rsp_hi, rsp_overflow, rsp_zero,
                          rsp_illegal}, {1'b1, 1'b0, 8'h00, 8'h00, 3'b000});
    reset_n = 1'b1;

    do_op("add_ovf", 3'd2, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    do_op("sub_zero", 3'd3, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    do_op("nor", 3'd5, 8'hF0, 8'h0C, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    do_op("slt_neg", 3'd4, 8'hFE, 8'h03, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    do_op("slt_pos", 3'd4, 8'h03, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    do_op("and", 3'd0, 8'hCA, 8'h5F, 8'h4A, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    do_op("or", 3'd1, 8'h81, 8'h18, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    do_op("mulu_ff", 3'd6, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 8);
    do_op("mulu_small", 3'd6, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 8);
    do_op("mulu_zero", 3'd6, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8);
    do_op("illegal", 3'd7, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 0);

    // Backpressure: response held while a second request is presented.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_a = 8'h10; req_b = 8'h20;
    @(negedge clk);
    req_op = 3'd1; req_a = 8'hAA; req_b = 8'h55;
    @(negedge clk);
    check("bp_valid", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, req_ready, rsp_result, rsp_hi}, {1'b1, 1'b0, 8'h30, 8'h00});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_released", {req_ready, rsp_valid}, {1'b1, 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_next_accepted", 32'(req_ready), 32'h0);
    @(negedge clk);
    check("bp_next_result", {rsp_valid, rsp_result}, {1'b1, 8'hFF});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Asynchronous reset during the fourth multiply iteration.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd6; req_a = 8'h0D; req_b = 8'h0B;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_ready_valid", {req_ready, rsp_valid}, {1'b1, 1'b0});
    check("rst_mid_alu", {alu_a, alu_b, alu_ain, alu_bin, alu_operation, alu_cin}, 32'h0);
    check("rst_mid_rsp", {rsp_result, rsp_hi, rsp_overflow, rsp_zero, rsp_illegal}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op("add_after_rst", 3'd2, 8'h02, 8'h03, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
Initiator-side controller for the team's 8-bit ripple ALU. Its outputs drive the ALU's operand, invert, operation and carry-in inputs, and it reads back the ALU's RESULT and OVERFLOW.
- Accepts operation requests over a valid/ready handshake and translates each opcode into ALU control settings.
- Sequences an 8-iteration unsigned shift-add multiply through the ALU adder.
- Returns results over a valid/ready response channel.
- Sits between the datapath/instruction front end and the ALU instance.

Parameters:
MUL_ITERS, 8, multiply iterations; equals the operand width and is fixed at 8.

Ports:
CLK  in  1  single clock, rising edge.
RESET_N  in  1  reset, asynchronous, active-low.
REQ_VALID  in  1  request valid.
REQ_READY  out  1  controller can accept a request.
REQ_OP  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MULU, 111 illegal.
REQ_A  in  8  operand A.
REQ_B  in  8  operand B.
ALU_A  out  8  ALU operand A (registered).
ALU_B  out  8  ALU operand B (registered).
ALU_AIN  out  1  ALU A-invert.
ALU_BIN  out  1  ALU B-invert.
ALU_OPERATION  out  2  ALU select: 00 AND, 01 OR, 10 ADD, 11 SLT.
ALU_CIN  out  1  ALU carry-in.
ALU_RESULT  in  8  ALU result (combinational from the ALU_* outputs).
ALU_OVERFLOW  in  1  ALU signed overflow.
RSP_VALID  out  1  response valid.
RSP_READY  in  1  consumer accepts the response.
RSP_RESULT  out  8  result; MULU low byte.
RSP_HI  out  8  MULU high byte; 0 for all other ops.
RSP_OVERFLOW  out  1  ADD/SUB: ALU overflow; MULU: RSP_HI != 0; otherwise 0.
RSP_ZERO  out  1  RSP_RESULT==0, and for MULU also RSP_HI==0.
RSP_ILLEGAL  out  1  opcode 111 received.

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE; all outputs 0 except REQ_READY=1. This applies mid-operation: any in-flight op or pending response is discarded.
- Opcode decode, as {AIN,BIN,OPERATION,CIN}:
  - AND = 0,0,00,0
  - OR = 0,0,01,0
  - ADD = 0,0,10,0
  - SUB = 0,1,10,1
  - SLT = 0,1,11,1
  - NOR = 1,1,00,0
  - MULU iterations use ADD.
- States: IDLE, EXEC, MUL, RESP. REQ_READY is high only in IDLE.
- IDLE: all ALU_* outputs driven 0.
  - On REQ_VALID&REQ_READY at edge k: latch the operands and load the ALU_* registers.
  - Next state is EXEC for ops 000-101, MUL for 110, RESP for 111.
  - Opcode 111: RSP_ILLEGAL=1, RSP_RESULT=0, RSP_ZERO=1.
- EXEC: the ALU settles combinationally. At edge k+1, capture ALU_RESULT/ALU_OVERFLOW into the RSP registers and go to RESP. RSP_VALID is high from edge k+1, i.e. 1-cycle latency.
- MUL: registers are acc(8), mplr(8), mcand(8), cnt(3). At accept: acc=0, mplr=REQ_B, mcand=REQ_A, cnt=0.
  - Each cycle drive ALU_A=acc, ALU_B=(mplr[0] ? mcand : 0), ADD.
  - Carry = (a7&b7) | ((a7|b7) & ~ALU_RESULT[7]).
  - At the edge: {acc,mplr} = {carry, ALU_RESULT, mplr[7:1]}; cnt++.
  - After the 8th iteration (edge k+8): RSP_HI=acc, RSP_RESULT=mplr; go to RESP.
- RESP: RSP_VALID=1 and all RSP_* held stable until RSP_READY is sampled high. On that handshake edge: RSP_VALID=0, go to IDLE; REQ_READY rises at the same edge. There is no request/response bypass.
- Only one operation is in flight. REQ_* inputs are ignored outside IDLE.
- SLT is the raw ALU result (sign of A-B, not corrected for overflow); the controller does not correct it.
- ALU_* outputs hold their last value in RESP and return to 0 on entry to IDLE.

Decomposition:
- Shared package holds:
  - opcode constants (OP_AND..OP_ILL);
  - ALU select constants (ALUSEL_AND/OR/ADD/SLT);
  - state encoding (IDLE/EXEC/MUL/RESP);
  - the decode-tuple typedef {ain,bin,sel,cin}.
- One natural sub-module: ula_op_decode, a combinational function from opcode to decode tuple.
- The multiply datapath stays inline.

Test Plan:
- The bench instantiates ula_seq_ctrl driving the team's 8-bit ALU.
- ADD A=0x7F B=0x01 -> RSP_VALID one cycle after accept; RESULT=0x80, OVERFLOW=1, ZERO=0.
- SUB A=0x05 B=0x05 -> RESULT=0x00, ZERO=1, OVERFLOW=0; NOR A=0xF0 B=0x0C -> RESULT=0x03.
- SLT A=0xFE B=0x03 -> RESULT=0x01; SLT A=0x03 B=0xFE -> RESULT=0x00.
- MULU A=0xFF B=0xFF -> RSP_VALID at accept+8; HI=0xFE, RESULT=0x01, OVERFLOW=1. MULU A=0x0D B=0x0B -> HI=0x00, RESULT=0x8F, OVERFLOW=0.
- Backpressure: hold RSP_READY=0 for 5 cycles -> RSP_* stable, REQ_READY=0 and a new request is ignored; release -> next request accepted the following cycle. Opcode 111 -> RSP_ILLEGAL=1, RESULT=0.
- RESET_N asserted at MUL iteration 4 -> all outputs 0 and REQ_READY=1 immediately. After release, ADD 0x02+0x03 -> RESULT=0x05.
